// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: shared constants and FSM state type for the AFE SPI register engine.
// Frame layout: 8-bit register address followed by 24-bit data, MSB first.
package afe_spi_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned ADDR_BITS  = 8;
    localparam int unsigned DATA_BITS  = 24;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } afe_spi_state_e;

endpackage

// File: rtl/afe_spi_engine_if.sv
// afe_spi_engine_if: host request/response signals plus the four SPI pins of the AFE link.
//   in_write_begin / in_read_begin : one-cycle request pulses (write wins if both)
//   in_addr / in_wdata             : register address and write data, sampled on begin
//   out_rdata                      : last read data, held until the next read completes
//   out_read_write_done / out_busy : completion pulse and in-progress flag
//   out_spi_sclk / out_spi_mosi / in_spi_miso / out_spi_ste_n : SPI mode 0 pins
//   out_protocol_er                : sticky begin-while-busy flag (AFE_SPI_PROTOCOL_ER_EN only)
// Modports: slave = the engine, master = the host/AFE side.
interface afe_spi_engine_if;
    import afe_spi_pkg::*;

    logic                 in_write_begin;
    logic                 in_read_begin;
    logic [ADDR_BITS-1:0] in_addr;
    logic [DATA_BITS-1:0] in_wdata;
    logic [DATA_BITS-1:0] out_rdata;
    logic                 out_read_write_done;
    logic                 out_busy;
    logic                 out_spi_sclk;
    logic                 out_spi_mosi;
    logic                 in_spi_miso;
    logic                 out_spi_ste_n;
`ifdef AFE_SPI_PROTOCOL_ER_EN
    logic                 out_protocol_er;
`endif

    modport slave (
        input  in_write_begin, in_read_begin, in_addr, in_wdata, in_spi_miso,
        output out_rdata, out_read_write_done, out_busy, out_spi_sclk, out_spi_mosi,
        output out_spi_ste_n
`ifdef AFE_SPI_PROTOCOL_ER_EN
        , output out_protocol_er
`endif
    );

    modport master (
        output in_write_begin, in_read_begin, in_addr, in_wdata, in_spi_miso,
        input  out_rdata, out_read_write_done, out_busy, out_spi_sclk, out_spi_mosi,
        input  out_spi_ste_n
`ifdef AFE_SPI_PROTOCOL_ER_EN
        , input out_protocol_er
`endif
    );

endinterface

// File: rtl/afe_spi_sclk_gen.sv
// afe_spi_sclk_gen: SCLK divider for the AFE SPI engine.
//   clk, in_reset_n : system clock, async active-low reset
//   i_en            : run enable; while low SCLK is held low and the phase counter cleared
//   o_sclk          : SCLK, CLK_DIV clk cycles low then CLK_DIV cycles high per bit
//   o_rise / o_fall : strobes valid in the cycle whose closing edge raises / lowers SCLK
module afe_spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic in_reset_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_sclk;
    logic       w_toggle;

    assign w_toggle = i_en && (r_cnt == DIV_LAST);
    assign o_rise   = w_toggle && !r_sclk;
    assign o_fall   = w_toggle && r_sclk;
    assign o_sclk   = r_sclk;

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_toggle) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/afe_spi_engine.sv
// afe_spi_engine: single-register read/write SPI master for an AFE (SPI mode 0, 32-bit frame).
//   clk, in_reset_n : system clock, async active-low reset
//   spi_bus         : afe_spi_engine_if.slave (host handshake + SPI pins)
// Parameters: CLK_DIV (SCLK half-period, 1..255), CS_SETUP / CS_HOLD (STE-to-SCLK guard
// cycles, 1..256). Done arrives CS_SETUP + 64*CLK_DIV + CS_HOLD + 1 cycles after begin.
// Optional: define AFE_SPI_PROTOCOL_ER_EN to add the sticky out_protocol_er flag.
module afe_spi_engine
    import afe_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic            clk,
    input  logic            in_reset_n,
    afe_spi_engine_if.slave spi_bus
);

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS - 1);

    afe_spi_state_e        r_state;
    afe_spi_state_e        w_state_next;
    logic [7:0]            r_tmr;
    logic [4:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_tx;
    logic [DATA_BITS-1:0]  r_rx;
    logic [DATA_BITS-1:0]  r_rdata;
    logic                  r_is_read;
    logic                  r_ste_n;
    logic                  w_begin;
    logic                  w_busy;
    logic                  w_sclk;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_cs_next;

    assign w_begin = spi_bus.in_write_begin || spi_bus.in_read_begin;
    assign w_busy  = (r_state != StIdle);

    afe_spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .in_reset_n (in_reset_n),
        .i_en       (r_state == StShift),
        .o_sclk     (w_sclk),
        .o_rise     (w_rise),
        .o_fall     (w_fall)
    );

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_begin) w_state_next = StSetup;
            StSetup: if (r_tmr == SETUP_LAST) w_state_next = StShift;
            StShift: if (w_fall && (r_bit_cnt == LAST_BIT)) w_state_next = StHold;
            StHold:  if (r_tmr == HOLD_LAST) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // STE is registered from the next state so the pin never glitches on state decode.
    assign w_cs_next = (w_state_next == StSetup) || (w_state_next == StShift) ||
                       (w_state_next == StHold);

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rdata   <= '0;
            r_is_read <= 1'b0;
            r_ste_n   <= 1'b1;
        end else begin
            r_ste_n <= !w_cs_next;

            if (w_state_next != r_state) begin
                r_tmr <= '0;
            end else if ((r_state == StSetup) || (r_state == StHold)) begin
                r_tmr <= r_tmr + 8'd1;
            end

            if ((r_state == StIdle) && w_begin) begin
                // Write wins a simultaneous request; reads send zeros in the data phase.
                r_is_read <= !spi_bus.in_write_begin;
                r_tx      <= {spi_bus.in_addr,
                              spi_bus.in_write_begin ? spi_bus.in_wdata : {DATA_BITS{1'b0}}};
                r_bit_cnt <= '0;
            end

            if (w_rise) begin
                r_rx <= {r_rx[DATA_BITS-2:0], spi_bus.in_spi_miso};
            end

            // Zero fill leaves MOSI low once the frame has been shifted out.
            if (w_fall) begin
                r_tx      <= {r_tx[FRAME_BITS-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end

            if ((r_state == StHold) && (w_state_next == StDone) && r_is_read) begin
                r_rdata <= r_rx;
            end
        end
    end

`ifdef AFE_SPI_PROTOCOL_ER_EN
    logic r_protocol_er;

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_protocol_er <= 1'b0;
        end else if (w_busy && w_begin) begin
            r_protocol_er <= 1'b1;
        end
    end

    assign spi_bus.out_protocol_er = r_protocol_er;
`endif

    assign spi_bus.out_rdata           = r_rdata;
    assign spi_bus.out_read_write_done = (r_state == StDone);
    assign spi_bus.out_busy            = w_busy;
    assign spi_bus.out_spi_sclk        = w_sclk;
    assign spi_bus.out_spi_mosi        = r_tx[FRAME_BITS-1];
    assign spi_bus.out_spi_ste_n       = r_ste_n;

endmodule

// File: tb/tb_afe_spi_engine.sv
// tb_afe_spi_engine: directed bench for afe_spi_engine (default and fast parameter sets).
// Cycle numbering: the cycle in which begin is high is cycle 0; done is expected in cycle
// CS_SETUP + 64*CLK_DIV + CS_HOLD + 1. Build with AFE_SPI_PROTOCOL_ER_EN to cover the flag.
module tb_afe_spi_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    afe_spi_engine_if bus ();
    afe_spi_engine_if bus_fast ();

    afe_spi_engine u_dut (
        .clk        (clk),
        .in_reset_n (rst_n),
        .spi_bus    (bus)
    );

    afe_spi_engine #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1)
    ) u_dut_fast (
        .clk        (clk),
        .in_reset_n (rst_n),
        .spi_bus    (bus_fast)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // AFE model, sampled on the falling clk edge: shifts out {8'h00, slave_word} in mode 0,
    // captures MOSI on SCLK rise, counts done pulses and MOSI changes while SCLK is high.
    logic [23:0] slave_word = 24'h0;
    logic [31:0] slave_tx   = 32'h0;
    int          slave_idx  = 0;
    logic [31:0] mosi_cap   = 32'h0;
    int          rise_cnt   = 0;
    int          done_cnt   = 0;
    int          mode_err   = 0;
    logic        prev_ste   = 1'b1;
    logic        prev_sclk  = 1'b0;
    logic        prev_mosi  = 1'b0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            bus.in_spi_miso = 1'b0;
        end else if (prev_ste && !bus.out_spi_ste_n) begin
            slave_tx        = {8'h00, slave_word};
            bus.in_spi_miso = slave_tx[31];
            slave_idx       = 30;
            mosi_cap        = 32'h0;
            rise_cnt        = 0;
        end else if (!bus.out_spi_ste_n) begin
            if (!prev_sclk && bus.out_spi_sclk) begin
                mosi_cap = {mosi_cap[30:0], bus.out_spi_mosi};
                rise_cnt++;
            end
            if (prev_sclk && !bus.out_spi_sclk && slave_idx >= 0) begin
                bus.in_spi_miso = slave_tx[slave_idx];
                slave_idx--;
            end
        end
        if (!bus.out_spi_ste_n && bus.out_spi_sclk && (bus.out_spi_mosi !== prev_mosi))
            mode_err++;
        if (bus.out_read_write_done === 1'b1) done_cnt++;
        prev_ste  = bus.out_spi_ste_n;
        prev_sclk = bus.out_spi_sclk;
        prev_mosi = bus.out_spi_mosi;
    end

    // Caller sits #1 after a posedge; begin is driven in the next cycle and returns in cycle 1.
    task automatic start_frame(input bit wr, input bit rd, input logic [7:0] a,
                               input logic [23:0] d);
        @(posedge clk); #1;
        bus.in_write_begin = wr;
        bus.in_read_begin  = rd;
        bus.in_addr        = a;
        bus.in_wdata       = d;
        @(posedge clk); #1;
        bus.in_write_begin = 1'b0;
        bus.in_read_begin  = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat, output logic [23:0] rd_at,
                             output logic ste_at);
        lat    = -1;
        rd_at  = 24'h0;
        ste_at = 1'b0;
        for (int c = c0; c <= 400; c++) begin
            if (bus.out_read_write_done === 1'b1) begin
                lat    = c;
                rd_at  = bus.out_rdata;
                ste_at = bus.out_spi_ste_n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [7:0]  addr;
        logic [23:0] wdata;
        logic [23:0] miso;
        logic [31:0] exp_mosi;
        logic [23:0] exp_rdata;
    } vec_t;

    vec_t        vecs[6];
    int          lat;
    logic [23:0] rdv;
    logic        stev;
    int          lat_fast;
    int          rises_fast;
    int          sclk_bad;
    logic        prev_fast;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h00, 24'h000008, 24'hFFFFFF, 32'h00000008, 24'h000000};
        vecs[1] = '{1'b0, 1'b1, 8'h30, 24'h000000, 24'hA5C3F0, 32'h30000000, 24'hA5C3F0};
        vecs[2] = '{1'b1, 1'b0, 8'h7E, 24'h123456, 24'h0F0F0F, 32'h7E123456, 24'hA5C3F0};
        vecs[3] = '{1'b1, 1'b1, 8'h01, 24'hABCDEF, 24'h3C3C3C, 32'h01ABCDEF, 24'hA5C3F0};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 24'h999999, 24'h5A5A5A, 32'hFF000000, 24'h5A5A5A};
        vecs[5] = '{1'b0, 1'b1, 8'h81, 24'h777777, 24'h000001, 32'h81000000, 24'h000001};

        bus.in_write_begin      = 1'b0;
        bus.in_read_begin       = 1'b0;
        bus.in_addr             = 8'h00;
        bus.in_wdata            = 24'h0;
        bus_fast.in_write_begin = 1'b0;
        bus_fast.in_read_begin  = 1'b0;
        bus_fast.in_addr        = 8'h00;
        bus_fast.in_wdata       = 24'h0;
        bus_fast.in_spi_miso    = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ste_n", bus.out_spi_ste_n, 1);
        check("reset sclk", bus.out_spi_sclk, 0);
        check("reset mosi", bus.out_spi_mosi, 0);
        check("reset done", bus.out_read_write_done, 0);
        check("reset busy", bus.out_busy, 0);
        check("reset rdata", bus.out_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Table frames run back to back: each begin lands in the first idle cycle after DONE.
        for (int i = 0; i < 6; i++) begin
            slave_word = vecs[i].miso;
            start_frame(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d busy", i), bus.out_busy, 1);
            check($sformatf("v%0d ste_n", i), bus.out_spi_ste_n, 0);
            wait_done(1, lat, rdv, stev);
            check($sformatf("v%0d latency", i), lat, 261);
            check($sformatf("v%0d mosi", i), mosi_cap, vecs[i].exp_mosi);
            check($sformatf("v%0d sclk rises", i), rise_cnt, 32);
            check($sformatf("v%0d rdata", i), {8'h0, rdv}, {8'h0, vecs[i].exp_rdata});
            check($sformatf("v%0d ste_n at done", i), stev, 1);
        end

`ifdef AFE_SPI_PROTOCOL_ER_EN
        check("protocol_er clean", bus.out_protocol_er, 0);
`endif

        // A read request during cycle 100 of a write must be dropped.
        slave_word = 24'h777777;
        start_frame(1'b1, 1'b0, 8'h42, 24'h00C0DE);
        repeat (99) begin @(posedge clk); #1; end
        bus.in_read_begin = 1'b1;
        bus.in_addr       = 8'h99;
        bus.in_wdata      = 24'h111111;
        @(posedge clk); #1;
        bus.in_read_begin = 1'b0;
        wait_done(101, lat, rdv, stev);
        check("busy-begin latency", lat, 261);
        check("busy-begin mosi", mosi_cap, 32'h4200C0DE);
        check("busy-begin rdata", {8'h0, rdv}, 32'h000001);
        repeat (5) begin @(posedge clk); #1; end
        check("busy-begin no queued frame", bus.out_busy, 0);
`ifdef AFE_SPI_PROTOCOL_ER_EN
        check("protocol_er set", bus.out_protocol_er, 1);
        repeat (20) begin @(posedge clk); #1; end
        check("protocol_er sticky", bus.out_protocol_er, 1);
`endif

        // Reset asserted mid-cycle during cycle 50 of a read (SCLK high at that point).
        slave_word = 24'hA5C3F0;
        start_frame(1'b0, 1'b1, 8'h30, 24'h0);
        repeat (49) begin @(posedge clk); #1; end
        check("pre-reset sclk", bus.out_spi_sclk, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort ste_n", bus.out_spi_ste_n, 1);
        check("abort sclk", bus.out_spi_sclk, 0);
        check("abort busy", bus.out_busy, 0);
        check("abort mosi", bus.out_spi_mosi, 0);
        check("abort done", bus.out_read_write_done, 0);
        check("abort rdata", bus.out_rdata, 0);
`ifdef AFE_SPI_PROTOCOL_ER_EN
        check("protocol_er cleared", bus.out_protocol_er, 0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n             = 1'b1;
        bus.in_read_begin = 1'b1;
        bus.in_addr       = 8'h30;
        @(posedge clk); #1;
        bus.in_read_begin = 1'b0;
        check("post-reset accept", bus.out_busy, 1);
        wait_done(1, lat, rdv, stev);
        check("post-reset latency", lat, 261);
        check("post-reset mosi", mosi_cap, 32'h30000000);
        check("post-reset rdata", {8'h0, rdv}, 32'hA5C3F0);

        // Fast instance: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 -> SHIFT in cycles 2..65, done 67.
        @(posedge clk); #1;
        bus_fast.in_write_begin = 1'b1;
        bus_fast.in_addr        = 8'h5A;
        bus_fast.in_wdata       = 24'h00FFFF;
        @(posedge clk); #1;
        bus_fast.in_write_begin = 1'b0;
        lat_fast   = -1;
        rises_fast = 0;
        sclk_bad   = 0;
        prev_fast  = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c >= 2 && c <= 65 && (bus_fast.out_spi_sclk !== (((c - 2) % 2) == 1)))
                sclk_bad++;
            if (!prev_fast && bus_fast.out_spi_sclk === 1'b1) rises_fast++;
            prev_fast = bus_fast.out_spi_sclk;
            if (bus_fast.out_read_write_done === 1'b1 && lat_fast < 0) lat_fast = c;
            if (c < 100) begin @(posedge clk); #1; end
        end
        check("fast latency", lat_fast, 67);
        check("fast sclk period", sclk_bad, 0);
        check("fast sclk rises", rises_fast, 32);

        repeat (300) @(posedge clk);
        #1;
        check("total done pulses", done_cnt, 8);
        check("mosi stable while sclk high", mode_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
